ir_prefetch_queue: RTL
======================

// Module: ir_prefetch_queue
// PURPOSE
//  Parametrised successor of the single DLX instruction register: a DEPTH-entry
//  instruction prefetch queue whose head entry is the current IR. Field decode
//  (opcode, func, RS1/RS2/RD, imm, SEXT) is driven from the head entry.
//  Sits between the memory data-in bus and the control state machine/GPR file.
// PARAMETERS
//  DATA_W  32  instruction width; field positions assume 32
//  DEPTH   4   queue entries; power of 2, >= 2
//  IMM_W   16  immediate width; SEXT width = DATA_W-IMM_W
// PORTS
//  CLK       in   1          clock, rising edge
//  RESET_N   in   1          asynchronous reset, active low
//  DI        in   DATA_W     instruction word from memory
//  DI_VALID  in   1          DI holds a word to enqueue
//  DI_READY  out  1          queue can accept DI this cycle
//  DI_PAR    in   1          even-parity bit of DI (used only with IR_PARITY_EN)
//  IRCE      in   1          consume head (advance IR)
//  FLUSH     in   1          discard all entries (branch/jump taken)
//  JLINK     in   1          force RD to link register 31
//  IR_VALID  out  1          head entry valid
//  IR_OUT    out  DATA_W     head instruction; 0 when !IR_VALID
//  IR_31_26  out  6          opcode
//  IR_5_0    out  6          func
//  RS1       out  5          IR[25:21]
//  RS2       out  5          IR[20:16]
//  RD        out  5          see BEHAVIOUR
//  imm       out  IMM_W      IR[IMM_W-1:0]
//  SEXT      out  DATA_W-IMM_W  {(DATA_W-IMM_W){IR[IMM_W-1]}}
//  COUNT     out  $clog2(DEPTH+1)  occupied entries
//  PAR_ERR   out  1          head parity error
// BEHAVIOUR
//  - Reset: COUNT=0, pointers=0, storage=0, IR_VALID=0, IR_OUT=0, PAR_ERR=0;
//    DI_READY=1 once RESET_N deasserts.
//  - DI_READY = (COUNT != DEPTH); registered-state only, no IRCE->READY path.
//  - Push when DI_VALID&&DI_READY at a rising edge; visible at head next cycle
//    at the earliest (1-cycle latency, no bypass).
//  - Pop when IRCE&&IR_VALID; IRCE with IR_VALID=0 is ignored.
//  - Push+pop same edge: COUNT unchanged, both pointers advance.
//  - Full: DI_READY=0, DI ignored. Pointers wrap modulo DEPTH.
//  - FLUSH has priority: next COUNT=0, pointers=0; any push/pop the same edge
//    is discarded.
//  - RD = JLINK ? 5'd31 : (opcode==6'h00 ? IR[15:11] : IR[20:16]);
//    JLINK applies even when !IR_VALID.
//  - Decode outputs are combinational from IR_OUT; the head word is 0 when empty.
//  - RESET_N asserted mid-operation clears the queue immediately; entries are lost.
// CONFIGURATION
//  IR_PARITY_EN defined: each entry stores DI_PAR; PAR_ERR = IR_VALID &&
//    (^IR_OUT ^ stored_par). Error is flagged only; the entry is still consumed.
//  IR_PARITY_EN undefined: DI_PAR ignored, PAR_ERR tied 0, no parity storage.
// STRUCTURE
//  - dlx_ir_pkg: opcode/func/RS1/RS2/RD/imm bit-position localparams,
//    OPC_RTYPE=6'h00, RD_LINK=5'd31.
//  - Sub-module ir_field_decode: combinational field/RD/SEXT extraction from
//    IR_OUT and JLINK.
//  - Top level holds the storage array, pointers, COUNT and handshake.
// TESTING
//  1 Reset, push 32'h8C010011 -> next cycle IR_VALID=1, IR_31_26=6'h23,
//    RS1=0, RD=1, imm=16'h0011, SEXT=16'h0000, COUNT=1.
//  2 Push 32'h00432023, pop the first word -> IR_31_26=0, RS1=2, RS2=3, RD=4,
//    IR_5_0=6'h23; JLINK=1 -> RD=31.
//  3 Push 32'h8C01FFF0 -> imm=16'hFFF0, SEXT=16'hFFFF.
//  4 Push 5 words with IRCE=0 (DEPTH=4) -> DI_READY=0 after the 4th push,
//    5th dropped, COUNT=4; pop 4 -> order preserved across wrap, IR_VALID=0, IR_OUT=0.
//  5 At COUNT=2, assert FLUSH with DI_VALID=1 and IRCE=1 -> next COUNT=0,
//    IR_VALID=0, pushed word absent.
//  6 IR_PARITY_EN: push 32'h00000001 with DI_PAR=0 -> PAR_ERR=1 at head;
//    same word with DI_PAR=1 -> PAR_ERR=0. Without macro -> PAR_ERR=0 always.
//    Assert RESET_N low mid-fill -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dlx_ir_pkg.sv
// dlx_ir_pkg: DLX instruction field positions and fixed encodings shared by the IR queue.
package dlx_ir_pkg;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;
    localparam int RS1_HI  = 25;
    localparam int RS1_LO  = 21;
    localparam int RS2_HI  = 20;
    localparam int RS2_LO  = 16;
    localparam int RDR_HI  = 15;
    localparam int RDR_LO  = 11;
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [4:0] RD_LINK   = 5'd31;
endpackage

// File: rtl/ir_field_decode.sv
// ir_field_decode: combinational DLX field, destination-register and sign-extension decode.
module ir_field_decode
    import dlx_ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [DATA_W-1:0]       ir_i,
    input  logic                    jlink_i,
    output logic [5:0]              opcode_o,
    output logic [5:0]              func_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [4:0]              rd_o,
    output logic [IMM_W-1:0]        imm_o,
    output logic [DATA_W-IMM_W-1:0] sext_o
);
    assign opcode_o = ir_i[OPC_HI:OPC_LO];
    assign func_o   = ir_i[FUNC_HI:FUNC_LO];
    assign rs1_o    = ir_i[RS1_HI:RS1_LO];
    assign rs2_o    = ir_i[RS2_HI:RS2_LO];
    assign imm_o    = ir_i[IMM_W-1:0];
    assign sext_o   = {(DATA_W-IMM_W){ir_i[IMM_W-1]}};
    // R-type writes the rd field; I-type writes the rs2 slot; JAL/JALR links to r31
    assign rd_o = jlink_i ? RD_LINK : (opcode_o == OPC_RTYPE ? ir_i[RDR_HI:RDR_LO] : rs2_o);
endmodule

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: DEPTH-entry instruction prefetch queue whose head entry is the DLX IR.
// Define IR_PARITY_EN to store an even-parity bit per entry and flag PAR_ERR at the head.
module ir_prefetch_queue
    import dlx_ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IMM_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_W-1:0]          di_i,
    input  logic                       di_valid_i,
    output logic                       di_ready_o,
    input  logic                       di_par_i,
    input  logic                       irce_i,
    input  logic                       flush_i,
    input  logic                       jlink_i,
    output logic                       ir_valid_o,
    output logic [DATA_W-1:0]          ir_out_o,
    output logic [5:0]                 ir_31_26_o,
    output logic [5:0]                 ir_5_0_o,
    output logic [4:0]                 rs1_o,
    output logic [4:0]                 rs2_o,
    output logic [4:0]                 rd_o,
    output logic [IMM_W-1:0]           imm_o,
    output logic [DATA_W-IMM_W-1:0]    sext_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       par_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    // Ready depends only on registered occupancy so there is no IRCE-to-READY path
    assign di_ready_o = count_q != CW'(DEPTH);
    assign ir_valid_o = count_q != '0;
    assign count_o    = count_q;
    assign push       = di_valid_i && di_ready_o;
    assign pop        = irce_i && ir_valid_o;
    assign ir_out_o   = ir_valid_o ? mem_q[rd_ptr_q] : '0;
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush_i) mem_q[wr_ptr_q] <= di_i;
        end
    end
`ifdef IR_PARITY_EN
    logic par_q [DEPTH];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= 1'b0;
        end else if (push && !flush_i) begin
            par_q[wr_ptr_q] <= di_par_i;
        end
    end
    // Flag only: the entry is still consumed normally
    assign par_err_o = ir_valid_o && (^ir_out_o ^ par_q[rd_ptr_q]);
`else
    logic unused_par;
    assign unused_par = di_par_i;
    assign par_err_o  = 1'b0;
`endif
    ir_field_decode #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_decode (
        .ir_i     (ir_out_o),
        .jlink_i  (jlink_i),
        .opcode_o (ir_31_26_o),
        .func_o   (ir_5_0_o),
        .rs1_o    (rs1_o),
        .rs2_o    (rs2_o),
        .rd_o     (rd_o),
        .imm_o    (imm_o),
        .sext_o   (sext_o)
    );
endmodule
